// File: rtl/serial_addsub_pkg.sv
// ============================================================================
// Module      : serial_addsub_pkg
// Description : Shared encodings for the bit-serial adder/subtractor:
//               FSM state values and operation select codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_addsub_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_SHIFT = ST_SHIFT,
      S_DONE  = ST_DONE
   } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_addsub_fulladder.sv
// ============================================================================
// Module      : serial_addsub_fulladder
// Description : Single-bit full-adder cell; the only arithmetic element of
//               the bit-serial adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_addsub_fulladder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic sum,
   output logic c_out
);

   assign sum   = a ^ b ^ c_in;
   assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/serial_addsub.sv
// ============================================================================
// Module      : serial_addsub
// Description : Bit-serial two's-complement adder/subtractor. One result bit
//               per clock, LSB first, through one full-adder cell. Subtract
//               is a + ~b + 1 (carry flop preset to 1).
//               Optional macro SERIAL_ADDSUB_ZERO_FLAG_EN adds a registered
//               'zero' result flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             c_out,
   output logic             overflow
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
   ,
   output logic             zero
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t          state, state_nxt;
   logic [WIDTH-1:0] opa_sr, opb_sr;
   logic             carry;
   logic [CW-1:0]    count;
   logic             cell_sum, cell_cout;
   logic             accept, last_bit;

   assign accept   = (state == S_IDLE) && start;
   assign last_bit = (state == S_SHIFT) && (count == LAST_BIT);

   assign busy = (state == S_SHIFT);
   assign done = (state == S_DONE);

   serial_addsub_fulladder u_cell (
      .a     (opa_sr[0]),
      .b     (opb_sr[0]),
      .c_in  (carry),
      .sum   (cell_sum),
      .c_out (cell_cout)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: IDLE -> SHIFT on start, SHIFT for WIDTH bits, one DONE cycle
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start)    state_nxt = S_SHIFT;
         S_SHIFT: if (last_bit) state_nxt = S_DONE;
         S_DONE:                state_nxt = S_IDLE;
         default:               state_nxt = S_IDLE;
      endcase
   end

   // Datapath: operand load on accepted start, one bit per cycle in SHIFT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opa_sr   <= '0;
         opb_sr   <= '0;
         carry    <= 1'b0;
         count    <= '0;
         result   <= '0;
         c_out    <= 1'b0;
         overflow <= 1'b0;
      end else if (accept) begin
         opa_sr   <= a;
         opb_sr   <= (op_sub == OP_SUB) ? ~b : b;
         carry    <= op_sub;
         count    <= '0;
         result   <= '0;
         c_out    <= 1'b0;
         overflow <= 1'b0;
      end else if (state == S_SHIFT) begin
         opa_sr <= opa_sr >> 1;
         opb_sr <= opb_sr >> 1;
         result <= {cell_sum, result[WIDTH-1:1]};
         carry  <= cell_cout;
         count  <= count + CW'(1);
         if (last_bit) begin
            c_out    <= cell_cout;
            overflow <= carry ^ cell_cout;
         end
      end
   end

`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
   logic sum_acc;

   // Zero flag: OR-accumulate sum bits, publish the inverse on the MSB cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_acc <= 1'b0;
         zero    <= 1'b0;
      end else if (accept) begin
         sum_acc <= 1'b0;
         zero    <= 1'b0;
      end else if (state == S_SHIFT) begin
         sum_acc <= sum_acc | cell_sum;
         if (last_bit) zero <= ~(sum_acc | cell_sum);
      end
   end
`endif

endmodule

`default_nettype wire
